// File: rtl/fmaaddpipe_pkg.sv
// Shared FMA configuration type and the widths derived from it.
package fmaaddpipe_pkg;

    typedef struct packed {
        int NF;
        int NE;
    } cvw_t;

    localparam cvw_t HALF_CFG = '{NF: 10, NE: 5};

    // Addend alignment window width
    function automatic int fmawa(cvw_t p);
        return 3*p.NF + 4;
    endfunction

    // Significand sum width (window plus one carry/borrow bit)
    function automatic int fmaws(cvw_t p);
        return 3*p.NF + 5;
    endfunction

endpackage

// File: rtl/fmaalign.sv
// Addend alignment: shifts Zm into the product window and collects sticky.
module fmaalign
    import fmaaddpipe_pkg::*;
#(
    parameter cvw_t P = HALF_CFG
) (
    input  logic [P.NE+1:0]         Pe,
    input  logic [P.NE-1:0]         Ze,
    input  logic [P.NF:0]           Zm,
    output logic [fmawa(P)-1:0]     Am,
    output logic                    ASticky,
    output logic                    KillProd
);

    localparam int NF = P.NF;
    localparam int NE = P.NE;
    localparam int WA = fmawa(P);

    logic signed [31:0] acnt;
    logic signed [31:0] shamt;
    logic [WA-1:0]      zmpre;
    logic [WA-1:0]      mask;

    assign acnt  = {{(32-(NE+2)){Pe[NE+1]}}, Pe} - {{(32-NE){1'b0}}, Ze};
    assign shamt = acnt + (NF + 3);
    assign zmpre = {Zm, {(2*NF+3){1'b0}}};

    // Select alignment case and shift the addend right by the exponent gap
    always_comb begin
        Am       = '0;
        ASticky  = 1'b0;
        KillProd = 1'b0;
        mask     = '0;
        if (shamt <= 0) begin
            KillProd = 1'b1;
            Am       = zmpre;
        end else if (shamt >= WA) begin
            ASticky = |Zm;
        end else begin
            mask    = ~({WA{1'b1}} << shamt);
            Am      = zmpre >> shamt;
            ASticky = |(zmpre & mask);
        end
    end

endmodule

// File: rtl/fmaaddpipe.sv
// Two-stage FMA addend alignment and significand addition with valid/ready.
module fmaaddpipe
    import fmaaddpipe_pkg::*;
#(
    parameter cvw_t P = HALF_CFG
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    Flush,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [2*P.NF+1:0]       Pm,
    input  logic                    Ps,
    input  logic [P.NE+1:0]         Pe,
    input  logic [P.NF:0]           Zm,
    input  logic                    Zs,
    input  logic [P.NE-1:0]         Ze,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [fmaws(P)-1:0]     Sm,
    output logic                    Ss,
    output logic [P.NE+1:0]         Se,
    output logic                    Sticky,
    output logic                    InvA
);

    localparam int NF = P.NF;
    localparam int NE = P.NE;
    localparam int WA = fmawa(P);
    localparam int WS = fmaws(P);

    typedef struct packed {
        logic [WA-1:0]     am;
        logic              asticky;
        logic              killprod;
        logic [2*NF+1:0]   pm;
        logic              ps;
        logic              zs;
        logic [NE+1:0]     pe;
        logic [NE-1:0]     ze;
    } s1_t;

    typedef struct packed {
        logic [WS-1:0]     sm;
        logic              ss;
        logic [NE+1:0]     se;
        logic              sticky;
        logic              inva;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic v1, v2, adv1, adv2;

    logic [WA-1:0] am;
    logic          asticky;
    logic          killprod;
    logic [WS:0]   pext, aext, raw;
    logic          inva;

    fmaalign #(.P(P)) u_align (
        .Pe       (Pe),
        .Ze       (Ze),
        .Zm       (Zm),
        .Am       (am),
        .ASticky  (asticky),
        .KillProd (killprod)
    );

    assign adv2     = ~v2 | OutReady;
    assign adv1     = ~v1 | adv2;
    assign InReady  = adv1;
    assign OutValid = v2;
    assign Sm       = s2_q.sm;
    assign Ss       = s2_q.ss;
    assign Se       = s2_q.se;
    assign Sticky   = s2_q.sticky;
    assign InvA     = s2_q.inva;

    // Pack the aligned addend with the pass-through operands for stage 1
    always_comb begin
        s1_d          = '0;
        s1_d.am       = am;
        s1_d.asticky  = asticky;
        s1_d.killprod = killprod;
        s1_d.pm       = Pm;
        s1_d.ps       = Ps;
        s1_d.zs       = Zs;
        s1_d.pe       = Pe;
        s1_d.ze       = Ze;
    end

    // Add or subtract in the window, then pick sign and magnitude.
    // The sum is formed one bit wider than WS so its MSB is a clean sign.
    always_comb begin
        inva = s1_q.ps ^ s1_q.zs;
        pext = (WS+1)'(s1_q.pm);
        aext = (WS+1)'(s1_q.am);
        raw  = pext + (inva ? ~aext : aext) + (WS+1)'(inva & ~s1_q.asticky);
        s2_d = '0;
        s2_d.inva = inva;
        if (s1_q.killprod) begin
            s2_d.sm     = WS'(s1_q.am);
            s2_d.ss     = s1_q.zs;
            s2_d.se     = {2'b00, s1_q.ze};
            s2_d.sticky = |s1_q.pm;
        end else begin
            if (inva && raw[WS]) begin
                s2_d.sm = ~raw[WS-1:0] + WS'(1);
                s2_d.ss = s1_q.zs;
            end else begin
                s2_d.sm = raw[WS-1:0];
                s2_d.ss = s1_q.ps;
            end
            s2_d.se     = s1_q.pe;
            s2_d.sticky = s1_q.asticky;
        end
        if (s2_d.sm == '0 && !s2_d.sticky)
            s2_d.ss = s1_q.ps & s1_q.zs;
    end

    // Stage valids: flush beats any accept, each stage moves on its own advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (Flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (adv2) v2 <= v1;
            if (adv1) v1 <= InValid;
        end
    end

    // Stage data: load only with valid contents, hold while stalled or flushed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (!Flush) begin
            if (adv1 && InValid) s1_q <= s1_d;
            if (adv2 && v1)      s2_q <= s2_d;
        end
    end

endmodule

// File: tb/tb_fmaaddpipe.sv
// Scoreboard bench for fmaaddpipe in the half configuration.
module tb_fmaaddpipe;
    import fmaaddpipe_pkg::*;

    localparam int NF = 10;
    localparam int NE = 5;
    localparam int WA = 3*NF + 4;
    localparam int WS = WA + 1;

    typedef struct packed {
        logic [2*NF+1:0] pm;
        logic            ps;
        logic [NE+1:0]   pe;
        logic [NF:0]     zm;
        logic            zs;
        logic [NE-1:0]   ze;
    } txn_t;

    typedef struct packed {
        logic [WS-1:0]   sm;
        logic            ss;
        logic [NE+1:0]   se;
        logic            sticky;
        logic            inva;
    } exp_t;

    logic            clk, reset_n, Flush, InValid, InReady, OutValid, OutReady;
    logic [2*NF+1:0] Pm;
    logic            Ps, Zs, Ss, Sticky, InvA;
    logic [NE+1:0]   Pe, Se;
    logic [NF:0]     Zm;
    logic [NE-1:0]   Ze;
    logic [WS-1:0]   Sm;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    bit   rand_rdy = 0;

    fmaaddpipe #(.P(HALF_CFG)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .Pm       (Pm),
        .Ps       (Ps),
        .Pe       (Pe),
        .Zm       (Zm),
        .Zs       (Zs),
        .Ze       (Ze),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Sm       (Sm),
        .Ss       (Ss),
        .Se       (Se),
        .Sticky   (Sticky),
        .InvA     (InvA)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: place Z and P on a common integer scale and add/subtract
    function automatic exp_t model(txn_t t);
        exp_t   e;
        int     pei, zei, shamt;
        longint zpre, am, r, one;
        bit     st;
        e    = '0;
        pei  = $signed(t.pe);
        zei  = int'(t.ze);
        zpre = longint'(t.zm) << (2*NF + 3);
        one  = 1;
        e.inva = t.ps ^ t.zs;
        shamt  = NF + 3 + pei - zei;
        if (shamt <= 0) begin
            e.sm     = WS'(zpre);
            e.ss     = t.zs;
            e.se     = {2'b00, t.ze};
            e.sticky = (t.pm != 0);
        end else begin
            if (shamt >= WA) begin
                am = 0;
                st = (t.zm != 0);
            end else begin
                am = zpre >> shamt;
                st = (zpre & ((one << shamt) - 1)) != 0;
            end
            if (e.inva) begin
                r = longint'(t.pm) - am;
                if (st) r = r - 1;
            end else begin
                r = longint'(t.pm) + am;
            end
            if (r < 0) begin
                r    = -r;
                e.ss = t.zs;
            end else begin
                e.ss = t.ps;
            end
            e.sm     = WS'(r);
            e.se     = t.pe;
            e.sticky = st;
        end
        if (e.sm == '0 && !e.sticky) e.ss = t.ps & t.zs;
        return e;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   d, pe;
        t.ze = NE'($urandom_range(0, 31));
        d    = int'($urandom_range(0, 80)) - 35;
        if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 4)) - 2;
        pe = int'(t.ze) + d;
        if (pe > 63)  pe = 63;
        if (pe < -64) pe = -64;
        t.pe = 7'(pe);
        t.pm = 22'($urandom);
        if ($urandom_range(0, 1) == 1) t.pm[2*NF] = 1'b1;
        t.zm = 11'($urandom);
        if ($urandom_range(0, 1) == 1) t.zm[NF] = 1'b1;
        if ($urandom_range(0, 7) == 0) t.zm = t.pm[2*NF:NF];
        if ($urandom_range(0, 15) == 0) begin
            t.zm = '0;
            t.pm = '0;
        end
        t.ps = 1'($urandom);
        t.zs = 1'($urandom);
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Present one operand set, push its expected result once accepted
    task automatic send(input txn_t t, input exp_t e);
        int n;
        n = 0;
        Pm = t.pm; Ps = t.ps; Pe = t.pe; Zm = t.zm; Zs = t.zs; Ze = t.ze;
        InValid = 1'b1;
        forever begin
            @(negedge clk);
            if (InReady) begin
                exp_q.push_back(e);
                acc_cnt++;
                break;
            end
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: InReady stuck low, expected accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic send_rand();
        txn_t t;
        t = rand_txn();
        send(t, model(t));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every transfer on the output side must match the queue head
    always @(negedge clk) begin
        exp_t act, req;
        if (reset_n && OutValid && OutReady) begin
            act = '{sm: Sm, ss: Ss, se: Se, sticky: Sticky, inva: InvA};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got sm=%0h ss=%b se=%0h sticky=%b inva=%b expected no output",
                         Sm, Ss, Se, Sticky, InvA);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    errors++;
                    $display("FAIL out%0d: got sm=%0h ss=%b se=%0h sticky=%b inva=%b expected sm=%0h ss=%b se=%0h sticky=%b inva=%b",
                             out_cnt, act.sm, act.ss, act.se, act.sticky, act.inva,
                             req.sm, req.ss, req.se, req.sticky, req.inva);
                end
            end
            out_cnt++;
        end
    end

    // Random back-pressure when enabled
    always @(posedge clk) begin
        #1;
        if (rand_rdy) OutReady = ($urandom_range(0, 3) != 0);
    end

    initial begin
        txn_t t;
        exp_t e;
        logic [WS-1:0] hold_sm;
        int base;

        reset_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        Pm = '0; Ps = 1'b0; Pe = '0; Zm = '0; Zs = 1'b0; Ze = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outvalid", 64'(OutValid), 64'd0);
        chk("reset_inready", 64'(InReady), 64'd1);
        chk("reset_data", 64'({Sm, Ss, Se, Sticky, InvA}), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Equal exponents, same sign; also measures latency
        t = '{pm: 22'h100000, ps: 1'b0, pe: 7'd15, zm: 11'h400, zs: 1'b0, ze: 5'd15};
        e = '{sm: 35'h200000, ss: 1'b0, se: 7'd15, sticky: 1'b0, inva: 1'b0};
        send(t, e);
        @(negedge clk);
        chk("latency_early", 64'(OutValid), 64'd0);
        @(negedge clk);
        chk("latency_due", 64'(OutValid), 64'd1);
        @(posedge clk);
        #1;

        t = '{pm: 22'h100000, ps: 1'b0, pe: 7'd15, zm: 11'h400, zs: 1'b1, ze: 5'd15};
        e = '{sm: 35'h0, ss: 1'b0, se: 7'd15, sticky: 1'b0, inva: 1'b1};
        send(t, e);
        t = '{pm: 22'h100000, ps: 1'b0, pe: 7'd15, zm: 11'h600, zs: 1'b1, ze: 5'd15};
        e = '{sm: 35'h80000, ss: 1'b1, se: 7'd15, sticky: 1'b0, inva: 1'b1};
        send(t, e);
        t = '{pm: 22'h123, ps: 1'b0, pe: 7'h76, zm: 11'h400, zs: 1'b0, ze: 5'd30};
        e = '{sm: 35'h200000000, ss: 1'b0, se: 7'd30, sticky: 1'b1, inva: 1'b0};
        send(t, e);
        t = '{pm: 22'h100000, ps: 1'b0, pe: 7'd45, zm: 11'h400, zs: 1'b0, ze: 5'd5};
        e = '{sm: 35'h100000, ss: 1'b0, se: 7'd45, sticky: 1'b1, inva: 1'b0};
        send(t, e);
        drain();

        // Back-pressure: pipe fills after two accepts, then all four drain in order
        OutReady = 1'b0;
        base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand();
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("bp_accepts", 64'(acc_cnt - base), 64'd2);
                chk("bp_inready", 64'(InReady), 64'd0);
                chk("bp_outvalid", 64'(OutValid), 64'd1);
                OutReady = 1'b1;
            end
        join
        drain();

        // Flush with both stages full
        OutReady = 1'b0;
        send_rand();
        send_rand();
        #1;
        chk("fl_full_outvalid", 64'(OutValid), 64'd1);
        chk("fl_full_inready", 64'(InReady), 64'd0);
        hold_sm = exp_q[0].sm;
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
        exp_q.delete();
        chk("fl_outvalid", 64'(OutValid), 64'd0);
        chk("fl_inready", 64'(InReady), 64'd1);
        chk("fl_data_hold", 64'(Sm), 64'(hold_sm));
        // Flush wins over a simultaneous accept
        t = rand_txn();
        Pm = t.pm; Ps = t.ps; Pe = t.pe; Zm = t.zm; Zs = t.zs; Ze = t.ze;
        OutReady = 1'b1;
        InValid = 1'b1;
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
        InValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fl_prio_outvalid", 64'(OutValid), 64'd0);

        // Asynchronous reset with both stages full
        OutReady = 1'b0;
        send_rand();
        send_rand();
        #1;
        chk("rst_full_outvalid", 64'(OutValid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_outvalid", 64'(OutValid), 64'd0);
        chk("rst_async_inready", 64'(InReady), 64'd1);
        chk("rst_async_data", 64'({Sm, Ss, Se, Sticky, InvA}), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        OutReady = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_stale", 64'(OutValid), 64'd0);

        // Random traffic under random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        drain();
        rand_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
